// File: rtl/fifo_traffic_gen.sv
// Multi-channel FIFO traffic generator/checker: per-channel counter or LFSR
// streams written to a tpc FIFO and verified on return from an fpc FIFO.

module fifo_traffic_gen_seq #(
  parameter int WIDTH = 64,
  parameter int CH    = 0
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic [31:0]      count_i,
  input  logic [3:0]       throttle_i,
  input  logic             avail_i,
  output logic             strobe_o,
  output logic [WIDTH-1:0] word_o,
  output logic             done_o,
  output logic             start_o
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2, DONE = 2'd3;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF ^ 32'(CH);

  logic [1:0]       state_q, state_d;
  logic             en_q;
  logic             mode_q, mode_d;
  logic [31:0]      count_q, count_d, k_q, k_d, lfsr_q, lfsr_d;
  logic [3:0]       gap_q, gap_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [31:0]      k_inc, lfsr_inc;
  logic             last_word;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [WIDTH-1:0] make_word(input logic m, input logic [31:0] k,
                                                 input logic [31:0] l);
    if (m) return {(WIDTH/32){l}};
    return {8'(CH), (WIDTH-8)'(k)};
  endfunction

  assign strobe_o  = (state_q == RUN) & avail_i;
  assign done_o    = (state_q == DONE);
  assign start_o   = enable_i & ~en_q & (state_q == IDLE);
  assign word_o    = word_q;
  assign k_inc     = k_q + 32'd1;
  assign lfsr_inc  = lfsr_step(lfsr_q);
  assign last_word = (count_q != 32'd0) && (k_inc == count_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    k_d     = k_q;
    lfsr_d  = lfsr_q;
    gap_d   = gap_q;
    last_d  = last_q;
    word_d  = word_q;
    case (state_q)
      IDLE: if (start_o) begin
        mode_d  = mode_i;
        count_d = count_i;
        k_d     = 32'd0;
        lfsr_d  = SEED;
        last_d  = 1'b0;
        word_d  = make_word(mode_i, 32'd0, SEED);
        state_d = RUN;
      end
      RUN: if (strobe_o) begin
        k_d    = k_inc;
        lfsr_d = lfsr_inc;
        last_d = last_word;
        word_d = make_word(mode_q, k_inc, lfsr_inc);
        if (throttle_i != 4'd0) begin
          gap_d   = throttle_i;
          state_d = GAP;
        end else if (last_word) begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (gap_q <= 4'd1) state_d = last_q ? DONE : RUN;
        else               gap_d   = gap_q - 4'd1;
      end
      default: ;
    endcase
    // Dropping enable aborts from any state; only a fresh rising edge restarts.
    if (!enable_i) state_d = IDLE;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      mode_q  <= 1'b0;
      count_q <= 32'd0;
      k_q     <= 32'd0;
      lfsr_q  <= SEED;
      gap_q   <= 4'd0;
      last_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= enable_i;
      mode_q  <= mode_d;
      count_q <= count_d;
      k_q     <= k_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      word_q  <= word_d;
    end
  end
endmodule

module fifo_traffic_gen #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 64,
  parameter int CW       = 16
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic [CHANNELS-1:0]       enable_i,
  input  logic [CHANNELS-1:0]       mode_i,
  input  logic [31:0]               count_i,
  input  logic [3:0]                throttle_i,
  input  logic [CHANNELS-1:0]       tpc_ready_i,
  output logic [CHANNELS-1:0]       tpc_write_o,
  output logic [CHANNELS*WIDTH-1:0] tpc_data_o,
  input  logic [CHANNELS-1:0]       fpc_valid_i,
  output logic [CHANNELS-1:0]       fpc_read_o,
  input  logic [CHANNELS*WIDTH-1:0] fpc_data_i,
  output logic [CHANNELS-1:0]       tx_done_o,
  output logic [CHANNELS-1:0]       rx_done_o,
  output logic [CHANNELS-1:0]       error_o,
  output logic [CHANNELS*CW-1:0]    error_count_o
);
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] exp_word;
      logic             gen_start, chk_start, mismatch;
      logic             err_q, err_d;
      logic [CW-1:0]    ecnt_q, ecnt_d;

      fifo_traffic_gen_seq #(.WIDTH(WIDTH), .CH(gi)) u_gen (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i[gi]),
        .mode_i(mode_i[gi]), .count_i(count_i), .throttle_i(throttle_i),
        .avail_i(tpc_ready_i[gi]), .strobe_o(tpc_write_o[gi]),
        .word_o(tpc_data_o[gi*WIDTH +: WIDTH]), .done_o(tx_done_o[gi]),
        .start_o(gen_start)
      );

      fifo_traffic_gen_seq #(.WIDTH(WIDTH), .CH(gi)) u_chk (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i[gi]),
        .mode_i(mode_i[gi]), .count_i(count_i), .throttle_i(throttle_i),
        .avail_i(fpc_valid_i[gi]), .strobe_o(fpc_read_o[gi]),
        .word_o(exp_word), .done_o(rx_done_o[gi]),
        .start_o(chk_start)
      );

      assign mismatch = fpc_read_o[gi] & (fpc_data_i[gi*WIDTH +: WIDTH] != exp_word);

      always_comb begin
        err_d  = err_q;
        ecnt_d = ecnt_q;
        if (gen_start | chk_start) begin
          err_d  = 1'b0;
          ecnt_d = '0;
        end else if (mismatch) begin
          err_d = 1'b1;
          if (ecnt_q != {CW{1'b1}}) ecnt_d = ecnt_q + 1'b1;
        end
      end

      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          err_q  <= 1'b0;
          ecnt_q <= '0;
        end else begin
          err_q  <= err_d;
          ecnt_q <= ecnt_d;
        end
      end

      assign error_o[gi]                = err_q;
      assign error_count_o[gi*CW +: CW] = ecnt_q;
    end
  endgenerate
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Directed bench: counter stream, LFSR loopback through a 16-deep FWFT FIFO,
// error injection, throttling, counter saturation, enable abort and async reset.

module tb_fifo_traffic_gen;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   en, mode, tpc_ready, tpc_write, fpc_valid, fpc_read;
  logic [1:0]   tx_done, rx_done, error;
  logic [31:0]  count;
  logic [3:0]   throttle;
  logic [127:0] tpc_data, fpc_data;
  logic [7:0]   ecnt;

  logic         ready1, valid1, lb_on, inj_on;
  logic [63:0]  fpc1_data, lb_head, inj_mask;
  logic [63:0]  mem [16];
  int           pushn = 0, popn = 0, pop_base = 0, push_base = 0;
  int           n_vec = 0, n_err = 0;

  localparam logic [63:0] BASE1 = 64'h0100_0000_0000_0000;

  fifo_traffic_gen #(.CHANNELS(2), .WIDTH(64), .CW(4)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(en), .mode_i(mode),
    .count_i(count), .throttle_i(throttle), .tpc_ready_i(tpc_ready),
    .tpc_write_o(tpc_write), .tpc_data_o(tpc_data), .fpc_valid_i(fpc_valid),
    .fpc_read_o(fpc_read), .fpc_data_i(fpc_data), .tx_done_o(tx_done),
    .rx_done_o(rx_done), .error_o(error), .error_count_o(ecnt)
  );

  always #5 clk = ~clk;

  // Loopback FIFO model on channel 0
  assign lb_head   = mem[popn % 16];
  assign inj_mask  = (inj_on && ((popn - pop_base) == 3 || (popn - pop_base) == 7))
                     ? 64'h20 : 64'h0;
  assign tpc_ready = {ready1, lb_on && ((pushn - popn) < 16)};
  assign fpc_valid = {valid1, lb_on && (pushn != popn)};
  assign fpc_data  = {fpc1_data, lb_head ^ inj_mask};

  always @(posedge clk) begin
    if (tpc_write[0]) begin
      mem[pushn % 16] <= tpc_data[63:0];
      pushn <= pushn + 1;
    end
    if (fpc_read[0]) popn <= popn + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0; en = 2'b00; mode = 2'b00; count = 32'd0; throttle = 4'd0;
    ready1 = 1'b0; valid1 = 1'b0; lb_on = 1'b0; inj_on = 1'b0; fpc1_data = 64'h0;
    repeat (3) @(negedge clk);
    chk("rst_tpc_write", 64'(tpc_write), 64'h0);
    chk("rst_tpc_data_hi", tpc_data[127:64], 64'h0);
    chk("rst_tpc_data_lo", tpc_data[63:0], 64'h0);
    chk("rst_done", 64'({tx_done, rx_done}), 64'h0);
    chk("rst_error", 64'({error, ecnt}), 64'h0);
    rst_n = 1'b1;

    // Counter stream on channel 1, count=4, back-to-back
    @(negedge clk);
    count = 32'd4; ready1 = 1'b1; en[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cnt_write", 64'(tpc_write[1]), 64'h1);
      chk("cnt_data", tpc_data[127:64], BASE1 + 64'(i));
    end
    @(negedge clk);
    chk("cnt_tx_done", 64'(tx_done[1]), 64'h1);
    chk("cnt_write_after", 64'(tpc_write[1]), 64'h0);
    chk("cnt_ch0_idle", 64'(tpc_write[0]), 64'h0);
    en[1] = 1'b0;
    @(negedge clk);
    chk("cnt_done_clr", 64'(tx_done[1]), 64'h0);

    // LFSR loopback on channel 0, count=100
    lb_on = 1'b1; mode[0] = 1'b1; count = 32'd100;
    pop_base = popn; push_base = pushn; en[0] = 1'b1;
    @(negedge clk);
    chk("lb_word0", tpc_data[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("lb_word1", tpc_data[63:0], 64'hFFDF_FFFC_FFDF_FFFC);
    @(negedge clk);
    chk("lb_word2", tpc_data[63:0], 64'h7FEF_FFFE_7FEF_FFFE);
    for (int i = 0; i < 2000 && !rx_done[0]; i++) @(negedge clk);
    chk("lb_rx_done", 64'(rx_done[0]), 64'h1);
    chk("lb_tx_done", 64'(tx_done[0]), 64'h1);
    chk("lb_error", 64'(error[0]), 64'h0);
    chk("lb_ecnt", 64'(ecnt[3:0]), 64'h0);
    chk("lb_pushed", 64'(pushn - push_base), 64'd100);
    chk("lb_popped", 64'(popn - pop_base), 64'd100);

    // Error injection: bit 5 flipped on returned words 3 and 7
    en[0] = 1'b0;
    @(negedge clk);
    count = 32'd10; pop_base = popn; inj_on = 1'b1; en[0] = 1'b1;
    for (int i = 0; i < 200 && (popn - pop_base) != 3; i++) @(negedge clk);
    chk("inj_at3_error", 64'(error[0]), 64'h0);
    for (int i = 0; i < 200 && (popn - pop_base) != 4; i++) @(negedge clk);
    chk("inj_after3_error", 64'(error[0]), 64'h1);
    chk("inj_after3_ecnt", 64'(ecnt[3:0]), 64'h1);
    for (int i = 0; i < 500 && !rx_done[0]; i++) @(negedge clk);
    chk("inj_rx_done", 64'(rx_done[0]), 64'h1);
    chk("inj_error", 64'(error[0]), 64'h1);
    chk("inj_ecnt", 64'(ecnt[3:0]), 64'h2);
    inj_on = 1'b0;

    // Throttle=3, ready held high: one write every fourth cycle
    count = 32'd8; throttle = 4'd3; ready1 = 1'b1; mode[1] = 1'b0; en[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("thr_duty", 64'(tpc_write[1]), ((i % 4) == 0) ? 64'h1 : 64'h0);
    end
    en[1] = 1'b0;
    @(negedge clk);

    // Throttle=1 with random ready: every word once, in order
    count = 32'd12; throttle = 4'd1; en[1] = 1'b1; k = 0;
    for (int i = 0; i < 400 && !tx_done[1]; i++) begin
      @(negedge clk);
      ready1 = 1'($urandom_range(0, 1));
      #1;
      if (tpc_write[1]) begin
        chk("rnd_data", tpc_data[127:64], BASE1 + 64'(k));
        k++;
      end
    end
    chk("rnd_words", 64'(k), 64'd12);
    chk("rnd_tx_done", 64'(tx_done[1]), 64'h1);
    en[1] = 1'b0; throttle = 4'd0;
    @(negedge clk);

    // Saturation: 20 mismatching words into channel 1 checker (CW=4)
    ready1 = 1'b0; valid1 = 1'b1; fpc1_data = 64'h0; count = 32'd20; en[1] = 1'b1;
    for (int i = 0; i < 100 && !rx_done[1]; i++) @(negedge clk);
    chk("sat_rx_done", 64'(rx_done[1]), 64'h1);
    chk("sat_ecnt", 64'(ecnt[7:4]), 64'hF);
    chk("sat_error", 64'(error[1]), 64'h1);
    repeat (3) @(negedge clk);
    chk("sat_hold", 64'(ecnt[7:4]), 64'hF);
    chk("sat_no_read", 64'(fpc_read[1]), 64'h0);
    chk("sat_ch0_indep", 64'(ecnt[3:0]), 64'h2);

    // Abort after 2 of 10 words, then restart from word 0
    valid1 = 1'b0; ready1 = 1'b1; count = 32'd10; en[1] = 1'b0;
    @(negedge clk);
    chk("abort_rx_done_clr", 64'(rx_done[1]), 64'h0);
    chk("abort_error_sticky", 64'(error[1]), 64'h1);
    en[1] = 1'b1;
    @(negedge clk);
    chk("abort_w0", tpc_data[127:64], BASE1);
    @(negedge clk);
    chk("abort_w1", tpc_data[127:64], BASE1 + 64'd1);
    chk("abort_w1_write", 64'(tpc_write[1]), 64'h1);
    en[1] = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'(tpc_write[1]), 64'h0);
    en[1] = 1'b1;
    @(negedge clk);
    chk("restart_w0", tpc_data[127:64], BASE1);
    chk("restart_error", 64'(error[1]), 64'h0);
    chk("restart_ecnt", 64'(ecnt[7:4]), 64'h0);
    chk("restart_tx_done", 64'(tx_done[1]), 64'h0);
    @(negedge clk);
    chk("restart_w1", tpc_data[127:64], BASE1 + 64'd1);

    // Asynchronous reset mid-run: outputs clear before the next edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_write", 64'(tpc_write), 64'h0);
    chk("arst_data_hi", tpc_data[127:64], 64'h0);
    chk("arst_data_lo", tpc_data[63:0], 64'h0);
    chk("arst_flags", 64'({tx_done, rx_done, error, fpc_read}), 64'h0);
    chk("arst_ecnt", 64'(ecnt), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
